// File: rtl/cal_eeprom_spi_slave.sv
// SPI mode-0 responder for the calibration EEPROM.
// All SPI pins are oversampled in the clk domain.
module cal_eeprom_spi_slave #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO,
  output logic wr_done,
  output logic rd_done,
  output logic frame_err
);

  localparam int FW    = 2 + ADDR_W + DATA_W;
  localparam int HW    = 2 + ADDR_W;
  localparam int CW    = $clog2(FW + 2);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  logic [SYNC_STAGES:0]   sclk_q, sclk_d;
  logic [SYNC_STAGES:0]   ss_q, ss_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FW-1:0]     rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic          sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic          mosi_s;
  logic [FW-1:0] rx_shift;
  logic [1:0]    op;

  // Extra flop beyond the synchronizer gives the edge pulses.
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign ss_fall   = ~ss_q[SYNC_STAGES-1] & ss_q[SYNC_STAGES];
  assign ss_rise   = ss_q[SYNC_STAGES-1] & ~ss_q[SYNC_STAGES];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign rx_shift  = {rx_q[FW-2:0], mosi_s};
  assign op        = rx_q[FW-1 -: 2];
  assign waddr     = rx_q[DATA_W +: ADDR_W];
  assign wdata     = rx_q[DATA_W-1:0];

  always_comb begin
    sclk_d = {sclk_q[SYNC_STAGES-1:0], SCLK};
    ss_d   = {ss_q[SYNC_STAGES-1:0], SS_n};
    if (SYNC_STAGES > 1) begin
      mosi_d = {mosi_q[SYNC_STAGES-2:0], MOSI};
    end else begin
      mosi_d = {SYNC_STAGES{MOSI}};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    err_d   = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = DONE;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          rx_d = rx_shift;
          if (cnt_q != CW'(FW + 1)) begin
            cnt_d = cnt_q + 1'b1;
          end
          // Header complete: fetch read data before the next fall.
          if (cnt_q == CW'(HW - 1) &&
              rx_shift[HW-1 -: 2] == 2'b00) begin
            tx_d = mem_q[rx_shift[ADDR_W-1:0]];
          end
        end else if (sclk_fall) begin
          miso_d = tx_q[DATA_W-1];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
      end
      DONE: begin
        miso_d  = 1'b0;
        state_d = IDLE;
        if (cnt_q == CW'(FW) && op == 2'b01) begin
          we   = 1'b1;
          wr_d = 1'b1;
        end else if (cnt_q == CW'(FW) && op == 2'b00) begin
          rd_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q  <= '0;
      ss_q    <= '0;
      mosi_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign MISO      = miso_q;
  assign wr_done   = wr_q;
  assign rd_done   = rd_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_cal_eeprom_spi_slave.sv
// Frame-level bench for cal_eeprom_spi_slave.
// Drives SPI frames and scores MISO byte and completion pulses.
module tb_cal_eeprom_spi_slave;

  logic clk = 1'b0;
  logic rst;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic wr_done;
  logic rd_done;
  logic frame_err;

  cal_eeprom_spi_slave dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .wr_done  (wr_done),
    .rd_done  (rd_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    int          nbits;
    int          rst_at;
    logic [7:0]  miso;
    int          wr;
    int          rd;
    int          err;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];
  vec_t sb [$];

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;

  always @(posedge clk) begin
    if (wr_done) wr_cnt <= wr_cnt + 1;
    if (rd_done) rd_cnt <= rd_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(
    input  logic [15:0] fr,
    input  int          nbits,
    input  int          rst_at,
    output logic [7:0]  got,
    output logic        early,
    output int          nw,
    output int          nr,
    output int          ne
  );
    int w0, r0, e0;
    got   = '0;
    early = 1'b0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    e0 = err_cnt;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 16) ? fr[15-i] : 1'b1;
      repeat (10) @(negedge clk);
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("miso_after_rst", int'(MISO), 0);
      end
      if (i >= 8 && i < 16) got[15-i] = MISO;
      else if (i < 8) early = early | MISO;
      SCLK = 1'b1;
      repeat (10) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (10) @(negedge clk);
    SS_n = 1'b1;
    repeat (14) @(negedge clk);
    nw = wr_cnt - w0;
    nr = rd_cnt - r0;
    ne = err_cnt - e0;
  endtask

  task automatic apply(input vec_t v, input int k);
    vec_t e;
    logic [7:0] got;
    logic early;
    int nw, nr, ne;
    sb.push_back(v);
    run_frame(v.frame, v.nbits, v.rst_at, got, early, nw, nr, ne);
    e = sb.pop_front();
    chk($sformatf("v%0d_%h_miso", k, e.frame), int'(got), int'(e.miso));
    chk($sformatf("v%0d_%h_early", k, e.frame), int'(early), 0);
    chk($sformatf("v%0d_%h_wr", k, e.frame), nw, e.wr);
    chk($sformatf("v%0d_%h_rd", k, e.frame), nr, e.rd);
    chk($sformatf("v%0d_%h_err", k, e.frame), ne, e.err);
  endtask

  initial begin
    tbl[0]  = '{16'h0500, 16, -1, 8'h00, 0, 1, 0};
    tbl[1]  = '{16'h4A3C, 16, -1, 8'h00, 1, 0, 0};
    tbl[2]  = '{16'h0A00, 16, -1, 8'h3C, 0, 1, 0};
    tbl[3]  = '{16'h0B00, 16, -1, 8'h00, 0, 1, 0};
    tbl[4]  = '{16'h0900, 16, -1, 8'h00, 0, 1, 0};
    tbl[5]  = '{16'h0100, 16, -1, 8'h00, 0, 1, 0};
    tbl[6]  = '{16'h7FFF, 16, -1, 8'h00, 1, 0, 0};
    tbl[7]  = '{16'h40A5, 16, -1, 8'h00, 1, 0, 0};
    tbl[8]  = '{16'h3F00, 16, -1, 8'hFF, 0, 1, 0};
    tbl[9]  = '{16'h0000, 16, -1, 8'hA5, 0, 1, 0};
    tbl[10] = '{16'h4722, 16, -1, 8'h00, 1, 0, 0};
    tbl[11] = '{16'h4711, 10, -1, 8'h00, 0, 0, 1};
    tbl[12] = '{16'h0700, 16, -1, 8'h22, 0, 1, 0};
    tbl[13] = '{16'h4711, 17, -1, 8'h00, 0, 0, 1};
    tbl[14] = '{16'h0700, 16, -1, 8'h22, 0, 1, 0};
    tbl[15] = '{16'h8A55, 16, -1, 8'h00, 0, 0, 1};
    tbl[16] = '{16'hCA55, 16, -1, 8'h00, 0, 0, 1};
    tbl[17] = '{16'h0A00, 16, -1, 8'h3C, 0, 1, 0};
    tbl[18] = '{16'h4211, 16, -1, 8'h00, 1, 0, 0};
    tbl[19] = '{16'h0200, 16, -1, 8'h11, 0, 1, 0};

    rst  = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    chk("reset_miso", int'(MISO), 0);
    chk("reset_wr_done", int'(wr_done), 0);
    chk("reset_rd_done", int'(rd_done), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    repeat (5) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      apply(tbl[k], k);
    end

    // Reset mid-read: MISO drops, no pulse, memory cleared.
    apply('{16'h0200, 16, 13, 8'h10, 0, 0, 0}, 100);
    apply('{16'h0200, 16, -1, 8'h00, 0, 1, 0}, 101);
    apply('{16'h0A00, 16, -1, 8'h00, 0, 1, 0}, 102);
    apply('{16'h3F00, 16, -1, 8'h00, 0, 1, 0}, 103);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
